fp16_normalizer: RTL and testbench

FP16_NORMALIZER -- requirements
Module: fp16_normalizer

---
 rtl/fp16_normalizer.sv | 156 +++++++++++++++
 tb/tb_fp16_normalizer.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/fp16_normalizer.sv
`default_nettype none
// ============================================================================
//  Module   : fp16_normalizer
//  Brief    : Post-add normalization stage for half-precision addition.
//             Takes the raw adder sum (carry, hidden bit, fraction, G/R/S),
//             shifts it until the hidden bit is in place, adjusts the
//             exponent and hands the result to the rounding stage with a
//             valid/ready handshake on both sides.
//  Revision : 1.0  initial release
// ============================================================================
module fp16_normalizer (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [14:0] raw_mantissa,
    input  logic [4:0]  raw_exponent,
    input  logic        raw_sign,
    input  logic        in_infinity,
    input  logic        in_NaN,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [12:0] normalized_mantissa,
    output logic [4:0]  normalized_exponent,
    output logic        sign,
    output logic        infinity_flag,
    output logic        NaN_flag
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_NORM = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [4:0] c_EXP_MAX = 5'd31;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [14:0] r_mant;
    logic [4:0]  r_exp;
    logic        r_sign;
    logic        r_inf;
    logic        r_nan;

    logic [14:0] w_mant_nxt;
    logic [4:0]  w_exp_nxt;
    logic        w_sign_nxt;
    logic        w_inf_nxt;
    logic        w_nan_nxt;
    logic [4:0]  w_exp_inc;

    // Exponent after a carry-out right shift; 5-bit wrap is intentional.
    assign w_exp_inc = r_exp + 5'd1;

    // State register; reset discards any operand in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and working-register update: load, then one normalization step per cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_mant_nxt  = r_mant;
        w_exp_nxt   = r_exp;
        w_sign_nxt  = r_sign;
        w_inf_nxt   = r_inf;
        w_nan_nxt   = r_nan;

        case (r_state)
            ST_IDLE: begin
                if (in_valid) begin
                    w_mant_nxt  = raw_mantissa;
                    w_exp_nxt   = raw_exponent;
                    w_sign_nxt  = raw_sign;
                    w_inf_nxt   = in_infinity;
                    w_nan_nxt   = in_NaN;
                    w_state_nxt = ST_NORM;
                end
            end

            ST_NORM: begin
                if (r_nan || r_inf) begin
                    // Special values pass through untouched.
                    w_state_nxt = ST_DONE;
                end else if (r_mant == 15'd0) begin
                    // Exact cancellation: true zero.
                    w_exp_nxt   = 5'd0;
                    w_state_nxt = ST_DONE;
                end else if (r_mant[14]) begin
                    // Carry out: shift right once, folding the dropped bit into sticky.
                    w_mant_nxt  = {1'b0, r_mant[14:2], r_mant[1] | r_mant[0]};
                    w_exp_nxt   = w_exp_inc;
                    if (w_exp_inc == c_EXP_MAX) begin
                        w_inf_nxt  = 1'b1;
                        w_mant_nxt = 15'd0;
                    end
                    w_state_nxt = ST_DONE;
                end else if (r_mant[13]) begin
                    // Already normalized.
                    w_state_nxt = ST_DONE;
                end else if (r_exp <= 5'd1) begin
                    // Cannot shift further without underflowing: emit a subnormal.
                    w_exp_nxt   = 5'd0;
                    w_state_nxt = ST_DONE;
                end else begin
                    // Leading-zero removal, one bit per cycle.
                    w_mant_nxt  = {r_mant[13:0], 1'b0};
                    w_exp_nxt   = r_exp - 5'd1;
                end
            end

            ST_DONE: begin
                if (out_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Working/output registers; cleared on reset, otherwise follow the step logic.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mant <= 15'd0;
            r_exp  <= 5'd0;
            r_sign <= 1'b0;
            r_inf  <= 1'b0;
            r_nan  <= 1'b0;
        end else begin
            r_mant <= w_mant_nxt;
            r_exp  <= w_exp_nxt;
            r_sign <= w_sign_nxt;
            r_inf  <= w_inf_nxt;
            r_nan  <= w_nan_nxt;
        end
    end

    assign in_ready            = (r_state == ST_IDLE);
    assign out_valid           = (r_state == ST_DONE);
    assign normalized_mantissa = r_mant[12:0];
    assign normalized_exponent = r_exp;
    assign sign                = r_sign;
    assign infinity_flag       = r_inf;
    assign NaN_flag            = r_nan;

endmodule
`default_nettype wire

// File: tb/tb_fp16_normalizer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fp16_normalizer
//  Brief    : Directed self-checking bench for fp16_normalizer.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fp16_normalizer;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [14:0] raw_mantissa;
    logic [4:0]  raw_exponent;
    logic        raw_sign;
    logic        in_infinity;
    logic        in_NaN;
    logic        out_valid;
    logic        out_ready;
    logic [12:0] normalized_mantissa;
    logic [4:0]  normalized_exponent;
    logic        sign;
    logic        infinity_flag;
    logic        NaN_flag;

    int n_checks = 0;
    int n_errors = 0;

    fp16_normalizer u_dut (
        .clk                 (clk),
        .rst                 (rst),
        .in_valid            (in_valid),
        .in_ready            (in_ready),
        .raw_mantissa        (raw_mantissa),
        .raw_exponent        (raw_exponent),
        .raw_sign            (raw_sign),
        .in_infinity         (in_infinity),
        .in_NaN              (in_NaN),
        .out_valid           (out_valid),
        .out_ready           (out_ready),
        .normalized_mantissa (normalized_mantissa),
        .normalized_exponent (normalized_exponent),
        .sign                (sign),
        .infinity_flag       (infinity_flag),
        .NaN_flag            (NaN_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Apply one operand; latency counts clock edges from the accept edge
    // (inclusive) to the edge after which out_valid is seen high.
    task automatic run_vec(input string tag,
                           input logic [14:0] m, input logic [4:0] e, input logic s,
                           input logic inf, input logic nan,
                           input logic [12:0] xm, input logic [4:0] xe,
                           input logic xinf, input logic xnan, input int xlat);
        int wait_cnt;
        int lat;
        wait_cnt = 0;
        while (!in_ready && wait_cnt < 20) begin
            step();
            wait_cnt++;
        end
        check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
        in_valid     = 1'b1;
        raw_mantissa = m;
        raw_exponent = e;
        raw_sign     = s;
        in_infinity  = inf;
        in_NaN       = nan;
        step();
        in_valid     = 1'b0;
        raw_mantissa = '0;
        raw_exponent = '0;
        raw_sign     = 1'b0;
        in_infinity  = 1'b0;
        in_NaN       = 1'b0;
        lat = 1;
        while (!out_valid && lat < 30) begin
            step();
            lat++;
        end
        check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        check({tag, "_latency"}, lat, xlat);
        check({tag, "_mant"}, {19'd0, normalized_mantissa}, {19'd0, xm});
        check({tag, "_exp"}, {27'd0, normalized_exponent}, {27'd0, xe});
        check({tag, "_inf"}, {31'd0, infinity_flag}, {31'd0, xinf});
        check({tag, "_nan"}, {31'd0, NaN_flag}, {31'd0, xnan});
        check({tag, "_sign"}, {31'd0, sign}, {31'd0, s});
        if (out_ready) begin
            step();
            check({tag, "_back_idle"}, {30'd0, in_ready, out_valid}, 32'd2);
        end
    endtask

    initial begin
        logic [12:0] hold_mant;
        logic [4:0]  hold_exp;
        int          rise_cnt;

        rst          = 1'b1;
        in_valid     = 1'b0;
        raw_mantissa = '0;
        raw_exponent = '0;
        raw_sign     = 1'b0;
        in_infinity  = 1'b0;
        in_NaN       = 1'b0;
        out_ready    = 1'b1;
        step();
        step();
        rst = 1'b0;

        // Reset state
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_outputs", {11'd0, normalized_mantissa, normalized_exponent, sign, infinity_flag, NaN_flag}, 32'd0);

        // Carry out: right shift, exponent +1
        run_vec("carry", 15'h6000, 5'd15, 1'b0, 1'b0, 1'b0, 13'h1000, 5'd16, 1'b0, 1'b0, 2);
        // Two left shifts
        run_vec("lshift2", 15'h0800, 5'd10, 1'b1, 1'b0, 1'b0, 13'h0000, 5'd8, 1'b0, 1'b0, 4);
        // One shift then subnormal stop
        run_vec("subnorm", 15'h0800, 5'd2, 1'b0, 1'b0, 1'b0, 13'h1000, 5'd0, 1'b0, 1'b0, 3);
        // Overflow to infinity
        run_vec("ovf", 15'h6000, 5'd30, 1'b1, 1'b0, 1'b0, 13'h0000, 5'd31, 1'b1, 1'b0, 2);
        // Sticky preserved on right shift
        run_vec("sticky", 15'h4003, 5'd5, 1'b0, 1'b0, 1'b0, 13'h0001, 5'd6, 1'b0, 1'b0, 2);
        // Zero result
        run_vec("zero", 15'h0000, 5'd12, 1'b0, 1'b0, 1'b0, 13'h0000, 5'd0, 1'b0, 1'b0, 2);
        // Already normalized
        run_vec("normd", 15'h2abc, 5'd9, 1'b1, 1'b0, 1'b0, 13'h0abc, 5'd9, 1'b0, 1'b0, 2);
        // Subnormal without shifting (exponent already 1)
        run_vec("sub_now", 15'h0100, 5'd1, 1'b0, 1'b0, 1'b0, 13'h0100, 5'd0, 1'b0, 1'b0, 2);
        // Maximum latency: 13 left shifts
        run_vec("maxlat", 15'h0001, 5'd20, 1'b0, 1'b0, 1'b0, 13'h0000, 5'd7, 1'b0, 1'b0, 15);
        // NaN and infinity pass through unchanged
        run_vec("nan", 15'h1234, 5'd7, 1'b1, 1'b1, 1'b1, 13'h1234, 5'd7, 1'b1, 1'b1, 2);
        run_vec("inf", 15'h4001, 5'd31, 1'b0, 1'b1, 1'b0, 13'h0001, 5'd31, 1'b1, 1'b0, 2);

        // Back-pressure: outputs hold while out_ready=0
        out_ready = 1'b0;
        run_vec("hold", 15'h0800, 5'd10, 1'b1, 1'b0, 1'b0, 13'h0000, 5'd8, 1'b0, 1'b0, 4);
        hold_mant = 13'h0000;
        hold_exp  = 5'd8;
        for (int i = 0; i < 5; i++) begin
            step();
            check("hold_valid", {30'd0, out_valid, in_ready}, 32'd2);
            check("hold_data", {14'd0, normalized_mantissa, normalized_exponent}, {14'd0, hold_mant, hold_exp});
        end
        out_ready = 1'b1;
        step();
        check("hold_release", {30'd0, in_ready, out_valid}, 32'd2);

        // Reset in the middle of a long normalization
        in_valid     = 1'b1;
        raw_mantissa = 15'h0001;
        raw_exponent = 5'd20;
        step();
        in_valid     = 1'b0;
        step();
        step();
        check("midrst_busy", {31'd0, in_ready}, 32'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        check("midrst_outputs", {14'd0, normalized_mantissa, normalized_exponent}, 32'd0);
        rise_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (out_valid) rise_cnt++;
            step();
        end
        check("midrst_no_valid", rise_cnt, 0);

        // Block still works after the aborted operand
        run_vec("after_rst", 15'h6000, 5'd15, 1'b0, 1'b0, 1'b0, 13'h1000, 5'd16, 1'b0, 1'b0, 2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
